// File: rtl/pixel_pkg.sv
// Shared pixel-path definitions: default lane geometry, packer FSM encoding and word-count helper.
// The packer state set grows by CSUM when PACK_CHECKSUM_EN is defined.
package pixel_pkg;

    localparam int PIX_W_DEF        = 8;
    localparam int PIX_PER_WORD_DEF = 5;

`ifdef PACK_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_CSUM,
        ST_DONE
    } pack_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } pack_state_t;
`endif

    // Words needed to hold num_pixels, last word possibly partial.
    function automatic int ceil_words(input int num_pixels, input int pix_per_word);
        return (num_pixels + pix_per_word - 1) / pix_per_word;
    endfunction

endpackage

// File: rtl/pixel_lane_shift.sv
// Packing register: writes one pixel into lane idx, clears to zero between words.
// Latency: a loaded lane appears on word the cycle after load.
// Backpressure: none; the owner pulses load only for an accepted pixel.
module pixel_lane_shift
    import pixel_pkg::*;
#(
    parameter int  PIX_W        = PIX_W_DEF,
    parameter int  PIX_PER_WORD = PIX_PER_WORD_DEF,
    localparam int WORD_W       = PIX_W * PIX_PER_WORD,
    localparam int IDX_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1
)(
    input  logic              CLK,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [IDX_W-1:0]  idx,
    input  logic [PIX_W-1:0]  pix,
    output logic [WORD_W-1:0] word
);

    always_ff @(posedge CLK) begin
        if (rst || clr) begin
            word <= '0;
        end else begin
            for (int i = 0; i < PIX_PER_WORD; i++) begin
                if (load && (idx == IDX_W'(i))) begin
                    word[i*PIX_W +: PIX_W] <= pix;
                end
            end
        end
    end

endmodule

// File: rtl/pixel_word_packer.sv
// Packs a serial pixel stream into PIX_PER_WORD-lane BRAM words at consecutive addresses; PACK_CHECKSUM_EN appends a 16-bit pixel-sum word.
// Latency: a word is written the cycle after its last lane is accepted; complete follows the final write by one cycle.
// Backpressure: pix_ready is high only in FILL, giving one stall cycle per word while it is written.
module pixel_word_packer
    import pixel_pkg::*;
#(
    parameter int  PIX_W        = PIX_W_DEF,
    parameter int  PIX_PER_WORD = PIX_PER_WORD_DEF,
    parameter int  NUM_PIXELS   = 1024,
    parameter int  ADDR_W       = 8,
    localparam int WORD_W       = PIX_W * PIX_PER_WORD
)(
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              complete,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [WORD_W-1:0] bram_din
);

    localparam int IDX_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int CNT_W = $clog2(NUM_PIXELS + 1);

    pack_state_t       state, next_state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  pix_cnt;
    logic [ADDR_W-1:0] word_cnt;
    logic [ADDR_W-1:0] addr_hold;
    logic [WORD_W-1:0] din_hold;
    logic [WORD_W-1:0] lane_word;
    logic              accept;
    logic              start_acc;

    assign accept    = pix_valid && (state == ST_FILL);
    assign start_acc = start && (state == ST_IDLE);

    always_ff @(posedge CLK) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        complete   = 1'b0;
        pix_ready  = 1'b0;
        bram_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_FILL;
            end
            ST_FILL: begin
                busy      = 1'b1;
                pix_ready = 1'b1;
                if (accept && (idx == IDX_W'(PIX_PER_WORD - 1) || pix_cnt == CNT_W'(NUM_PIXELS - 1)))
                    next_state = ST_WRITE;
            end
            ST_WRITE: begin
                busy    = 1'b1;
                bram_we = 1'b1;
                if (pix_cnt == CNT_W'(NUM_PIXELS))
`ifdef PACK_CHECKSUM_EN
                    next_state = ST_CSUM;
`else
                    next_state = ST_DONE;
`endif
                else
                    next_state = ST_FILL;
            end
`ifdef PACK_CHECKSUM_EN
            ST_CSUM: begin
                busy       = 1'b1;
                bram_we    = 1'b1;
                next_state = ST_DONE;
            end
`endif
            ST_DONE: begin
                complete   = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

`ifdef PACK_CHECKSUM_EN
    logic [15:0] csum;

    always_ff @(posedge CLK) begin
        if (rst || start_acc) csum <= '0;
        else if (accept)      csum <= csum + 16'(pix_in);
    end
`endif

    // Port A shows the live word while writing and holds the last write otherwise.
    always_comb begin
        bram_addr = addr_hold;
        bram_din  = din_hold;
        if (state == ST_WRITE) begin
            bram_addr = word_cnt;
            bram_din  = lane_word;
        end
`ifdef PACK_CHECKSUM_EN
        if (state == ST_CSUM) begin
            bram_addr = word_cnt;
            bram_din  = WORD_W'(csum);
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            idx       <= '0;
            pix_cnt   <= '0;
            word_cnt  <= '0;
            addr_hold <= '0;
            din_hold  <= '0;
        end else begin
            if (start_acc) begin
                idx      <= '0;
                pix_cnt  <= '0;
                word_cnt <= '0;
            end
            if (accept) begin
                idx     <= idx + 1'b1;
                pix_cnt <= pix_cnt + 1'b1;
            end
            if (state == ST_WRITE) begin
                idx      <= '0;
                word_cnt <= word_cnt + 1'b1;
            end
            if (bram_we) begin
                addr_hold <= bram_addr;
                din_hold  <= bram_din;
            end
        end
    end

    pixel_lane_shift #(
        .PIX_W        (PIX_W),
        .PIX_PER_WORD (PIX_PER_WORD)
    ) u_lane_shift (
        .CLK  (CLK),
        .rst  (rst),
        .clr  (start_acc || (state == ST_WRITE)),
        .load (accept),
        .idx  (idx),
        .pix  (pix_in),
        .word (lane_word)
    );

endmodule
